adc_sample_serializer: RTL and testbench

Output stage of the decimation chain: accepts 22-bit decimated samples qualified by the chain's `ce_out` strobe, buffers them in a small FIFO, and ships each one off-chip as a framed serial word (sample plus 2-bit sequence tag). It decouples the bursty decimator output from a slow, fixed-rate serial link. It reports buffer level and sticky overflow to the host.

---
 rtl/adc_sample_serializer.sv | 206 ++++++++++++++++++++
 tb/tb_adc_sample_serializer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_serializer.sv
//----------------------------------------------------------------------------
// adc_sample_serializer
//
// Output stage of the decimation chain. Decimated samples arrive on the
// filter_ce strobe, are tagged with a 2-bit sequence number, and are queued
// in a small FIFO. A serializer FSM pops one word at a time and ships it
// MSB first as a framed serial word on a slow, fixed-rate bit clock.
// Buffer occupancy and a sticky overflow flag are reported to the host.
//
// Optional feature macro: SER_PARITY_EN
//   defined   : an even-parity bit (XOR of the 24 word bits) follows bit 0,
//               giving a 25-bit frame.
//   undefined : plain 24-bit frame {sample, seq}.
//
// Parameters
//   DATA_W     sample width (default 22)
//   FIFO_DEPTH FIFO entries, power of 2, >= 2 (default 8)
//   BIT_DIV    clk cycles per serial bit, even, >= 2 (default 4)
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   clk_enable  in   global enable; when low every register holds
//   filter_in   in   signed sample, valid with filter_ce
//   filter_ce   in   single-cycle sample strobe
//   ovf_clear   in   clears overflow (a same-cycle drop wins)
//   ser_clk     out  serial bit clock, receiver samples on rising edge
//   ser_data    out  serial data, MSB first
//   ser_frame   out  high for the whole frame
//   fifo_level  out  occupied FIFO entries
//   overflow    out  sticky: a sample was dropped
//----------------------------------------------------------------------------
`timescale 1ns/1ps
module adc_sample_serializer #(
  parameter int DATA_W     = 22,
  parameter int FIFO_DEPTH = 8,
  parameter int BIT_DIV    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_enable,
  input  logic signed [DATA_W-1:0]    filter_in,
  input  logic                        filter_ce,
  input  logic                        ovf_clear,
  output logic                        ser_clk,
  output logic                        ser_data,
  output logic                        ser_frame,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);

  localparam int WORD_W = DATA_W + 2;
`ifdef SER_PARITY_EN
  localparam int FRAME_BITS = WORD_W + 1;
`else
  localparam int FRAME_BITS = WORD_W;
`endif
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = ADDR_W + 1;
  localparam int DIV_W  = $clog2(BIT_DIV);
  localparam int BCNT_W = $clog2(FRAME_BITS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  // Frame word as it leaves the shift register, parity appended when enabled.
  function automatic logic [FRAME_BITS-1:0] f_build_frame(input logic [WORD_W-1:0] word);
`ifdef SER_PARITY_EN
    return {word, ^word};
`else
    return word;
`endif
  endfunction

  // Control state
  logic [1:0]        r_state;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [BCNT_W-1:0] r_bit_cnt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [1:0]        r_seq;
  logic              r_ovf;

  // Datapath state (no reset: contents are only observed after a write/load)
  logic [WORD_W-1:0]     r_mem [FIFO_DEPTH];
  logic [WORD_W-1:0]     r_pop_word;
  logic [FRAME_BITS-1:0] r_shift;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_wr;
  logic              w_drop;
  logic              w_div_end;
  logic [WORD_W-1:0] w_wr_word;

  assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_div_end = (r_div_cnt == DIV_W'(BIT_DIV - 1));
  assign w_wr_word = {filter_in, r_seq};

  // Popping frees an entry in the same cycle, so a full FIFO still accepts
  // a strobe that coincides with the pop.
  assign w_pop  = clk_enable && (r_state == S_IDLE) && !w_empty;
  assign w_wr   = clk_enable && filter_ce && (!w_full || w_pop);
  assign w_drop = clk_enable && filter_ce && w_full && !w_pop;

  // FIFO storage, pop register and shift register
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_wr_word;
    end
    if (w_pop) begin
      r_pop_word <= r_mem[r_rd_ptr];
    end
    if (clk_enable) begin
      if (r_state == S_LOAD) begin
        r_shift <= f_build_frame(r_pop_word);
      end else if ((r_state == S_SHIFT) && w_div_end) begin
        r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  // FIFO bookkeeping, sequence tag, overflow and serializer FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_seq     <= 2'd0;
      r_ovf     <= 1'b0;
    end else if (clk_enable) begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase

      // Dropped samples still consume a tag so the receiver sees the gap.
      if (filter_ce) begin
        r_seq <= r_seq + 2'd1;
      end

      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clear) begin
        r_ovf <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_bit_cnt <= BCNT_W'(FRAME_BITS);
          r_div_cnt <= '0;
          r_state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_div_end) begin
            r_div_cnt <= '0;
            r_bit_cnt <= r_bit_cnt - BCNT_W'(1);
            // The gap reuses div_cnt, already back at 0 here.
            if (r_bit_cnt == BCNT_W'(1)) begin
              r_state <= S_GAP;
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        S_GAP: begin
          if (w_div_end) begin
            r_div_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Serial outputs are decoded from state so reset forces them low at once.
  assign ser_frame  = (r_state == S_SHIFT);
  assign ser_data   = (r_state == S_SHIFT) && r_shift[FRAME_BITS-1];
  assign ser_clk    = (r_state == S_SHIFT) && (r_div_cnt >= DIV_W'(BIT_DIV / 2));
  assign fifo_level = r_level;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_adc_sample_serializer.sv
`timescale 1ns/1ps
module tb_adc_sample_serializer;

  localparam int DATA_W     = 22;
  localparam int FIFO_DEPTH = 8;
  localparam int BIT_DIV    = 4;
  localparam int WORD_W     = DATA_W + 2;
`ifdef SER_PARITY_EN
  localparam int FB = WORD_W + 1;
  localparam logic [31:0] SINGLE_EXP = 32'h0155_5551;
`else
  localparam int FB = WORD_W;
  localparam logic [31:0] SINGLE_EXP = 32'h00AA_AAA8;
`endif
  localparam int BUSY   = (FB + 1) * BIT_DIV + 1;
  localparam int PERIOD = BUSY + 1;

  logic                     clk;
  logic                     reset;
  logic                     clk_enable;
  logic signed [DATA_W-1:0] filter_in;
  logic                     filter_ce;
  logic                     ovf_clear;
  logic                     ser_clk;
  logic                     ser_data;
  logic                     ser_frame;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                     overflow;

  adc_sample_serializer #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .BIT_DIV(BIT_DIV)
  ) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .filter_in(filter_in), .filter_ce(filter_ce), .ovf_clear(ovf_clear),
    .ser_clk(ser_clk), .ser_data(ser_data), .ser_frame(ser_frame),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of tagged words plus a busy countdown for the link
  logic [WORD_W-1:0] m_q[$];
  logic [31:0]       m_exp[$];
  int                m_busy;
  logic [1:0]        m_seq;
  logic              m_ovf;

  // Frame observer
  logic       mon_prev_clk, mon_prev_frame, mon_after_frame;
  logic [31:0] mon_word, last_word;
  int         mon_bits, mon_cyc, gap_cnt, frames_seen;
  bit         gap_chk;
  logic [1:0] mon_seqs[$];

  function automatic logic [31:0] frame_of(input logic [WORD_W-1:0] w);
`ifdef SER_PARITY_EN
    return {7'd0, w, ^w};
`else
    return {8'd0, w};
`endif
  endfunction

  function automatic logic [1:0] seq_of(input logic [31:0] w);
`ifdef SER_PARITY_EN
    return w[2:1];
`else
    return w[1:0];
`endif
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_exp.delete();
    m_busy = 0;
    m_seq = 2'd0;
    m_ovf = 1'b0;
    mon_prev_clk = 1'b0;
    mon_prev_frame = 1'b0;
    mon_after_frame = 1'b0;
    mon_word = '0;
    mon_bits = 0;
    mon_cyc = 0;
    gap_cnt = 0;
  endtask

  task automatic sample_and_check();
    check_eq("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    if (!ser_frame) check_eq("idle_outputs", {30'd0, ser_clk, ser_data}, 32'd0);
    if (ser_frame && ser_clk && !mon_prev_clk) begin
      mon_word = {mon_word[30:0], ser_data};
      mon_bits++;
    end
    if (ser_frame && !mon_prev_frame) begin
      if (gap_chk && mon_after_frame) check_eq("gap_cycles", 32'(gap_cnt), 32'(BIT_DIV + 2));
      mon_after_frame = 1'b0;
    end
    if (!ser_frame && mon_prev_frame) begin
      check_eq("frame_bits", 32'(mon_bits), 32'(FB));
      check_eq("frame_cycles", 32'(mon_cyc), 32'(FB * BIT_DIV));
      check_eq("frames_pending", 32'(m_exp.size()), 32'd1);
      if (m_exp.size() > 0) check_eq("frame_word", mon_word, m_exp.pop_front());
      last_word = mon_word;
      mon_seqs.push_back(seq_of(mon_word));
      frames_seen++;
      mon_word = '0;
      mon_bits = 0;
      mon_cyc = 0;
      gap_cnt = 0;
      mon_after_frame = 1'b1;
    end
    mon_prev_clk = ser_clk;
    mon_prev_frame = ser_frame;
  endtask

  // Called at a falling edge: drive inputs, advance the model, cross one
  // rising edge, then observe at the next falling edge.
  task automatic tick(input logic fce, input logic [DATA_W-1:0] din,
                      input logic clr, input logic ce);
    bit pop, full, setv;
    filter_ce = fce;
    filter_in = din;
    ovf_clear = clr;
    clk_enable = ce;
    if (ce && ser_frame) mon_cyc++;
    if (ce && !ser_frame && mon_after_frame) gap_cnt++;
    if (ce) begin
      pop  = (m_busy == 0) && (m_q.size() > 0);
      full = (m_q.size() == FIFO_DEPTH);
      setv = 1'b0;
      if (pop) begin
        m_exp.push_back(frame_of(m_q.pop_front()));
        m_busy = BUSY;
      end else if (m_busy > 0) begin
        m_busy--;
      end
      if (fce) begin
        if (!full || pop) m_q.push_back({din, m_seq});
        else setv = 1'b1;
        m_seq++;
      end
      if (setv) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    sample_and_check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic async_reset_mid();
    #2 reset = 1'b1;
    #1;
    check_eq("rst_ser_frame", 32'(ser_frame), 32'd0);
    check_eq("rst_ser_clk", 32'(ser_clk), 32'd0);
    check_eq("rst_ser_data", 32'(ser_data), 32'd0);
    check_eq("rst_fifo_level", 32'(fifo_level), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int guard;
    int rate;
    reset = 1'b1;
    clk_enable = 1'b0;
    filter_ce = 1'b0;
    filter_in = '0;
    ovf_clear = 1'b0;
    frames_seen = 0;
    gap_chk = 1'b0;
    last_word = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_eq("reset_ser_frame", 32'(ser_frame), 32'd0);
    check_eq("reset_ser_clk", 32'(ser_clk), 32'd0);
    check_eq("reset_ser_data", 32'(ser_data), 32'd0);
    check_eq("reset_fifo_level", 32'(fifo_level), 32'd0);
    check_eq("reset_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    idle(2);

    // Single frame and first-sample latency
    tick(1'b1, 22'h2AAAAA, 1'b0, 1'b1);
    check_eq("lat_level_n1", 32'(fifo_level), 32'd1);
    idle(1);
    check_eq("lat_level_n2", 32'(fifo_level), 32'd0);
    check_eq("lat_frame_n2", 32'(ser_frame), 32'd0);
    idle(1);
    check_eq("lat_frame_n3", 32'(ser_frame), 32'd1);
    check_eq("lat_msb_n3", 32'(ser_data), 32'd1);
    idle(FB * BIT_DIV + 10);
    check_eq("single_frames", 32'(frames_seen), 32'd1);
    check_eq("single_word", last_word, SINGLE_EXP);

    // Overflow from a fresh start: 10 back-to-back strobes
    async_reset_mid();
    mon_seqs.delete();
    gap_chk = 1'b1;
    for (int i = 0; i < 10; i++) tick(1'b1, DATA_W'($urandom), 1'b0, 1'b1);
    check_eq("ovf_set", 32'(overflow), 32'd1);
    check_eq("ovf_level", 32'(fifo_level), 32'd8);
    idle(9 * PERIOD + 20);
    gap_chk = 1'b0;
    check_eq("ovf_frames", 32'(mon_seqs.size()), 32'd9);
    for (int i = 0; i < 9 && i < mon_seqs.size(); i++)
      check_eq($sformatf("ovf_seq%0d", i), 32'(mon_seqs[i]), 32'(i % 4));
    tick(1'b1, DATA_W'($urandom), 1'b0, 1'b1);
    idle(PERIOD + 10);
    check_eq("seq_after_drop", 32'(seq_of(last_word)), 32'd2);

    // Set and clear in the same cycle
    tick(1'b0, '0, 1'b1, 1'b1);
    check_eq("clear_alone0", 32'(overflow), 32'd0);
    for (int i = 0; i < 9; i++) tick(1'b1, DATA_W'($urandom), 1'b0, 1'b1);
    tick(1'b1, DATA_W'($urandom), 1'b1, 1'b1);
    check_eq("collide_from0", 32'(overflow), 32'd1);
    tick(1'b1, DATA_W'($urandom), 1'b1, 1'b1);
    check_eq("collide_from1", 32'(overflow), 32'd1);
    tick(1'b0, '0, 1'b1, 1'b1);
    check_eq("clear_alone1", 32'(overflow), 32'd0);

    // Full FIFO: strobe lands in the pop cycle
    guard = 0;
    while (!(m_busy == 0 && m_q.size() > 0) && guard < 1000) begin
      idle(1);
      guard++;
    end
    check_eq("pop_wait_bound", 32'(guard < 1000), 32'd1);
    check_eq("full_before_pop", 32'(fifo_level), 32'd8);
    tick(1'b1, DATA_W'($urandom), 1'b0, 1'b1);
    check_eq("full_pop_level", 32'(fifo_level), 32'd8);
    check_eq("full_pop_ovf", 32'(overflow), 32'd0);
    idle((FIFO_DEPTH + 1) * PERIOD + 20);

    // Reset 40 cycles into a frame with 3 samples queued
    for (int i = 0; i < 4; i++) tick(1'b1, DATA_W'($urandom), 1'b0, 1'b1);
    idle(39);
    check_eq("pre_rst_level", 32'(fifo_level), 32'd3);
    check_eq("pre_rst_frame", 32'(ser_frame), 32'd1);
    async_reset_mid();
    guard = frames_seen;
    tick(1'b1, DATA_W'($urandom), 1'b0, 1'b1);
    idle(PERIOD + 10);
    check_eq("post_rst_frames", 32'(frames_seen - guard), 32'd1);
    check_eq("post_rst_seq", 32'(seq_of(last_word)), 32'd0);

    // Randomized traffic with enable gaps and clears
    for (int seg = 0; seg < 6; seg++) begin
      rate = (seg % 2) ? 30 : 150;
      for (int c = 0; c < 500; c++)
        tick(($urandom_range(0, rate - 1) == 0), DATA_W'($urandom),
             ($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0));
    end
    idle((FIFO_DEPTH + 1) * PERIOD + 20);
    check_eq("drained_frames", 32'(m_exp.size()), 32'd0);
    check_eq("drained_level", 32'(fifo_level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
